// File: rtl/snake_dir_ctrl_if.sv
// Button/step inputs and direction outputs between the input stage and the game core.
// The master side drives buttons, PAUSE and step; the slave side returns direction state.
interface snake_dir_ctrl_if;
  logic       PAUSE;
  logic       UP;
  logic       DOWN;
  logic       LEFT;
  logic       RIGHT;
  logic       step;
  logic [1:0] move_dir;
  logic [1:0] pending;
  logic       key_pulse;
  logic       overflow;

  modport master (
    output PAUSE, UP, DOWN, LEFT, RIGHT, step,
    input  move_dir, pending, key_pulse, overflow
  );

  modport slave (
    input  PAUSE, UP, DOWN, LEFT, RIGHT, step,
    output move_dir, pending, key_pulse, overflow
  );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Snake direction input stage: sync + debounce four buttons, filter illegal turns,
// and queue up to two turn requests that are consumed one per game-tick step.
module snake_dir_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input logic             SYS_CLK,
  input logic             RST,
  snake_dir_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit index equals the direction code: 0 up, 1 down, 2 left, 3 right.
  logic [3:0]       raw;
  logic [3:0]       sync_p0;
  logic [3:0]       sync_p1;
  logic [3:0]       deb_p2;
  logic [3:0]       deb_p3;
  logic [CNT_W-1:0] cnt_p2 [4];

  logic [1:0] move_dir_r;
  logic [1:0] pend_r;
  logic       key_pulse_r;
  logic       overflow_r;
  logic [1:0] q0_r;
  logic [1:0] q1_r;

  logic [3:0] press;
  logic       single;
  logic [1:0] cand;
  logic [1:0] tail;
  logic [1:0] ref_dir;
  logic       req;
  logic       legal;
  logic       pop;
  logic [1:0] fill;
  logic       accept;
  logic       drop;
  logic [1:0] q0_n;
  logic [1:0] q1_n;
  logic [1:0] dir_n;
  logic [1:0] pend_n;

  function automatic logic [1:0] enc_dir(input logic [3:0] oh);
    case (oh)
      4'b0010: enc_dir = 2'd1;
      4'b0100: enc_dir = 2'd2;
      4'b1000: enc_dir = 2'd3;
      default: enc_dir = 2'd0;
    endcase
  endfunction

  // A turn is legal only onto the other axis; same axis means duplicate or reversal.
  function automatic logic legal_turn(input logic [1:0] c, input logic [1:0] r);
    legal_turn = (c[1] != r[1]);
  endfunction

  assign raw = {bus.RIGHT, bus.LEFT, bus.DOWN, bus.UP};

  // Stage p0/p1: synchroniser; stage p2: debounced level; p3: previous level for edges
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      deb_p2  <= '0;
      deb_p3  <= '0;
      for (int i = 0; i < 4; i++) cnt_p2[i] <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      deb_p3  <= deb_p2;
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] != deb_p2[i]) begin
          if (cnt_p2[i] == CNT_MAX) begin
            deb_p2[i] <= sync_p1[i];
            cnt_p2[i] <= '0;
          end else begin
            cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
          end
        end else begin
          cnt_p2[i] <= '0;
        end
      end
    end
  end

  // Request filtering and queue next-state, evaluated against pre-pop state
  always_comb begin
    press   = deb_p2 & ~deb_p3;
    single  = (press != 4'd0) && ((press & (press - 4'd1)) == 4'd0);
    cand    = enc_dir(press);
    tail    = (pend_r == 2'd2) ? q1_r : q0_r;
    ref_dir = (pend_r != 2'd0) ? tail : move_dir_r;
    req     = single & ~bus.PAUSE;
    legal   = req & legal_turn(cand, ref_dir);
    pop     = bus.step & ~bus.PAUSE & (pend_r != 2'd0);
    fill    = pend_r - 2'(pop);
    accept  = legal & (fill != 2'd2);
    drop    = legal & (fill == 2'd2);

    q0_n  = q0_r;
    q1_n  = q1_r;
    dir_n = move_dir_r;
    if (pop) begin
      dir_n = q0_r;
      q0_n  = q1_r;
    end
    if (accept) begin
      if (fill == 2'd0) q0_n = cand;
      else              q1_n = cand;
    end
    pend_n = fill + 2'(accept);
  end

  // Stage p4: registered control outputs
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      move_dir_r  <= 2'd0;
      pend_r      <= 2'd0;
      key_pulse_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      move_dir_r  <= dir_n;
      pend_r      <= pend_n;
      key_pulse_r <= accept;
      overflow_r  <= overflow_r | drop;
    end
  end

  // Queue entries are only read while pending covers them, so they need no reset.
  always_ff @(posedge SYS_CLK) begin
    q0_r <= q0_n;
    q1_r <= q1_n;
  end

  assign bus.move_dir  = move_dir_r;
  assign bus.pending   = pend_r;
  assign bus.key_pulse = key_pulse_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Randomised and directed bench for snake_dir_ctrl with a queue-based reference model
// and a cycle scoreboard drained by an independent monitor.
module tb_snake_dir_ctrl;
  localparam int DEB = 4;

  logic SYS_CLK = 1'b0;
  logic RST;

  snake_dir_ctrl_if bus ();

  snake_dir_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
    .SYS_CLK (SYS_CLK),
    .RST     (RST),
    .bus     (bus)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  typedef struct {
    logic       kp;
    logic [1:0] md;
    logic [1:0] pend;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   kp_seen  = 0;

  // Reference model state: a plain queue of directions plus button histories.
  int         mq[$];
  logic [1:0] m_dir = 2'd0;
  logic       m_ovf = 1'b0;
  logic [3:0] m_deb = 4'd0;
  logic [3:0] m_deb_prev = 4'd0;
  logic [3:0] m_rawd[$];
  logic [3:0] m_sh[$];

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [1:0] opposite(input logic [1:0] d);
    case (d)
      2'd0: opposite = 2'd1;
      2'd1: opposite = 2'd0;
      2'd2: opposite = 2'd3;
      default: opposite = 2'd2;
    endcase
  endfunction

  // Advance the model across one clock edge with the given inputs.
  task automatic model_step(input logic r, input logic p, input logic s, input logic [3:0] b);
    exp_t       e;
    logic [3:0] pr;
    logic [1:0] cand;
    logic [1:0] rd;
    logic       legal;
    logic       do_pop;
    logic [3:0] smp;
    logic       all_diff;
    e.kp  = 1'b0;
    cand  = 2'd0;
    legal = 1'b0;
    if (r) begin
      m_dir = 2'd0;
      mq.delete();
      m_ovf = 1'b0;
      m_deb = 4'd0;
      m_deb_prev = 4'd0;
      m_rawd.delete();
      m_rawd.push_back(4'd0);
      m_rawd.push_back(4'd0);
      m_sh.delete();
    end else begin
      pr = m_deb & ~m_deb_prev;
      do_pop = s && !p && (mq.size() > 0);
      if ($countones(pr) == 1 && !p) begin
        for (int i = 0; i < 4; i++) if (pr[i]) cand = 2'(i);
        rd = (mq.size() > 0) ? 2'(mq[$]) : m_dir;
        legal = (cand != rd) && (cand != opposite(rd));
      end
      if (do_pop) m_dir = 2'(mq.pop_front());
      if (legal) begin
        if (mq.size() < 2) begin
          mq.push_back(int'(cand));
          e.kp = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      smp = m_rawd.pop_front();
      m_rawd.push_back(b);
      m_sh.push_back(smp);
      if (m_sh.size() > DEB) void'(m_sh.pop_front());
      m_deb_prev = m_deb;
      if (m_sh.size() == DEB) begin
        for (int i = 0; i < 4; i++) begin
          all_diff = 1'b1;
          foreach (m_sh[j]) if (m_sh[j][i] == m_deb[i]) all_diff = 1'b0;
          if (all_diff) m_deb[i] = ~m_deb[i];
        end
      end
    end
    e.md   = m_dir;
    e.pend = 2'(mq.size());
    e.ovf  = m_ovf;
    exp_q.push_back(e);
  endtask

  exp_t mon_e;
  always @(posedge SYS_CLK) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("key_pulse", int'(bus.key_pulse), int'(mon_e.kp));
      chk("move_dir",  int'(bus.move_dir),  int'(mon_e.md));
      chk("pending",   int'(bus.pending),   int'(mon_e.pend));
      chk("overflow",  int'(bus.overflow),  int'(mon_e.ovf));
    end
    if (bus.key_pulse === 1'b1) kp_seen++;
  end

  task automatic tick(input logic r, input logic p, input logic s, input logic [3:0] b);
    @(negedge SYS_CLK);
    RST = r;
    bus.PAUSE = p;
    bus.step = s;
    {bus.RIGHT, bus.LEFT, bus.DOWN, bus.UP} = b;
    model_step(r, p, s, b);
    @(posedge SYS_CLK);
    #2;
  endtask

  task automatic press(input logic [3:0] b, input int hold, input int rel,
                       input int step_at, input logic p);
    for (int i = 1; i <= hold; i++) tick(1'b0, p, (i == step_at), b);
    for (int i = 1; i <= rel; i++) tick(1'b0, p, 1'b0, 4'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int kp0;
    int sel;
    int n;
    logic [3:0] b;
    RST = 1'b1;
    bus.PAUSE = 1'b0;
    bus.step = 1'b0;
    {bus.RIGHT, bus.LEFT, bus.DOWN, bus.UP} = 4'd0;

    // Clean RIGHT press, then consume it.
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    chk("reset_move_dir", int'(bus.move_dir), 0);
    chk("reset_pending", int'(bus.pending), 0);
    kp0 = kp_seen;
    press(4'b1000, 12, 8, 0, 1'b0);
    chk("t1_key_pulses", kp_seen - kp0, 1);
    chk("t1_pending", int'(bus.pending), 1);
    tick(1'b0, 1'b0, 1'b1, 4'd0);
    chk("t1_move_dir", int'(bus.move_dir), 3);
    chk("t1_pending_after_step", int'(bus.pending), 0);

    // Bouncing LEFT never settles long enough.
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    kp0 = kp_seen;
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b0, ((i / 2) % 2 == 0) ? 4'b0100 : 4'd0);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0, 4'd0);
    chk("t2_key_pulses", kp_seen - kp0, 0);
    chk("t2_pending", int'(bus.pending), 0);
    chk("t2_move_dir", int'(bus.move_dir), 0);

    // Reversal and duplicate filtering.
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    press(4'b0010, 10, 8, 0, 1'b0);
    chk("t3_down_rejected", int'(bus.pending), 0);
    press(4'b0100, 10, 8, 0, 1'b0);
    press(4'b1000, 10, 8, 0, 1'b0);
    chk("t3_pending", int'(bus.pending), 1);

    // Full queue and overflow, then drain.
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    press(4'b0100, 10, 8, 0, 1'b0);
    press(4'b0010, 10, 8, 0, 1'b0);
    press(4'b1000, 10, 8, 0, 1'b0);
    chk("t4_pending", int'(bus.pending), 2);
    chk("t4_overflow", int'(bus.overflow), 1);
    tick(1'b0, 1'b0, 1'b1, 4'd0);
    chk("t4_step1_dir", int'(bus.move_dir), 2);
    tick(1'b0, 1'b0, 1'b1, 4'd0);
    chk("t4_step2_dir", int'(bus.move_dir), 1);
    chk("t4_drained", int'(bus.pending), 0);
    tick(1'b0, 1'b0, 1'b1, 4'd0);
    chk("t4_empty_step_dir", int'(bus.move_dir), 1);

    // Chord discard, then push and pop on the same edge with a full queue.
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    kp0 = kp_seen;
    press(4'b0101, 10, 8, 0, 1'b0);
    chk("t5_chord_pulses", kp_seen - kp0, 0);
    chk("t5_chord_pending", int'(bus.pending), 0);
    press(4'b0100, 10, 8, 0, 1'b0);
    press(4'b0010, 10, 8, 0, 1'b0);
    press(4'b1000, 10, 8, 7, 1'b0);
    chk("t5_pending", int'(bus.pending), 2);
    chk("t5_dir", int'(bus.move_dir), 2);
    chk("t5_overflow", int'(bus.overflow), 0);

    // Pause holds everything; reset clears a full queue.
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    kp0 = kp_seen;
    press(4'b0100, 10, 8, 5, 1'b1);
    chk("t6_pause_pulses", kp_seen - kp0, 0);
    chk("t6_pause_pending", int'(bus.pending), 0);
    press(4'b0100, 10, 8, 0, 1'b0);
    press(4'b0010, 10, 8, 0, 1'b0);
    chk("t6_full", int'(bus.pending), 2);
    tick(1'b1, 1'b0, 1'b0, 4'd0);
    chk("t6_rst_dir", int'(bus.move_dir), 0);
    chk("t6_rst_pending", int'(bus.pending), 0);
    chk("t6_rst_overflow", int'(bus.overflow), 0);

    // Random traffic against the reference model.
    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3, 4: begin
          b = 4'b0001 << $urandom_range(0, 3);
          press(b, $urandom_range(2, 14), $urandom_range(2, 10),
                $urandom_range(0, 14), ($urandom_range(0, 9) == 0));
        end
        5: begin
          b = 4'b0001 << $urandom_range(0, 3);
          n = $urandom_range(8, 20);
          for (int i = 0; i < n; i++)
            tick(1'b0, 1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1) ? b : 4'd0);
        end
        6: press(4'($urandom_range(0, 15)), $urandom_range(4, 12), 8, $urandom_range(0, 12), 1'b0);
        7: for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, ($urandom_range(0, 1) == 1), 4'd0);
        8: begin
          if ($urandom_range(0, 3) == 0) tick(1'b1, 1'b0, 1'b0, 4'd0);
          else tick(1'b0, 1'b0, 1'b1, 4'd0);
        end
        default: begin
          n = $urandom_range(4, 16);
          for (int i = 0; i < n; i++)
            tick(1'b0, 1'b1, ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)));
        end
      endcase
    end

    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 4'd0);
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
Upstream input stage for the snake game core. It conditions the four raw direction buttons (synchronise, debounce, press-edge detect), filters illegal turns, and buffers up to two turn requests. On each game-tick strobe it hands the game core one stable move_dir. This removes combinational button sampling from the game core and stops a double press within one tick from reversing the snake into itself.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples required before a button level is accepted (10 ms at 50 MHz)
CNT_W, 19, debounce counter width; must hold DEBOUNCE_CYCLES

Ports:
SYS_CLK  in  1  system clock; all logic on its rising edge
RST  in  1  synchronous active-high reset
PAUSE  in  1  level; high freezes queue consumption and discards presses
UP  in  1  raw button, active high, asynchronous
DOWN  in  1  raw button, active high, asynchronous
LEFT  in  1  raw button, active high, asynchronous
RIGHT  in  1  raw button, active high, asynchronous
step  in  1  one-cycle strobe from the game core at each move tick
move_dir  out  2  current direction: 00 up, 01 down, 10 left, 11 right
pending  out  2  queued requests, 0..2
key_pulse  out  1  one-cycle strobe for each accepted request
overflow  out  1  sticky; set when a legal request is dropped because the queue is full

Behaviour:
- Reset (RST high at a clock edge): move_dir=00, pending=0, key_pulse=0, overflow=0. Synchronisers, debounced levels and debounce counters all clear to 0. Reset overrides every other input in that cycle.
- Sync: each button passes through a 2-flop synchroniser.
- Debounce, per button: when the synchronised level differs from the debounced level, the counter increments; otherwise the counter clears. When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the new value and the counter clears.
- Press event: a rising edge of the debounced level produces a one-cycle internal pulse. Release edges are ignored.
- Simultaneous press events from two or more buttons in the same cycle are all discarded.
- Candidate request: the single press event, encoded as a 2-bit direction. Its reference is the queue tail if pending>0, otherwise move_dir. The reference is taken before any same-cycle pop.
- Reject the candidate if it equals the reference (duplicate) or is opposite to it (same bit1, different bit0: 00/01 or 10/11). A rejected candidate leaves all state unchanged and gives no key_pulse.
- Accept a legal candidate only if there is room after a same-cycle pop. On accept: push at the tail, and assert key_pulse in the next cycle.
- If the candidate is legal but there is no room, drop it and set overflow. overflow clears only on RST.
- Pop: on step=1 with PAUSE=0 and pending>0, move_dir takes the head entry in the next cycle and the queue shifts.
- step with an empty queue leaves move_dir unchanged.
- Simultaneous push and pop: the pop executes first and the push lands behind the popped entry. A push into an empty queue is never applied on the same step; it applies at the next step.
- PAUSE=1: step is ignored and press events are discarded, with no key_pulse and no overflow. Queue contents and move_dir are held. Debouncing keeps running, so a button held through the end of pause does not create a new press.
- Latency, clean press: 2 sync cycles + DEBOUNCE_CYCLES cycles to the debounced edge, +1 cycle to queue and key_pulse.
- pending wraps never: it saturates by construction at 2.

Test Plan:
(all tests use DEBOUNCE_CYCLES=4)
1. Reset, then hold RIGHT high 12 cycles -> exactly one key_pulse about 7 cycles after the press and pending=1. Then pulse step -> move_dir=11, pending=0.
2. Toggle LEFT every 2 cycles for 20 cycles, then hold low -> no key_pulse, pending=0, move_dir=00.
3. From reset (move_dir=00): press DOWN -> rejected, pending=0. Press LEFT, then RIGHT, before any step -> LEFT queued; RIGHT rejected as opposite of the tail; pending=1.
4. From move_dir=00: press LEFT, DOWN, RIGHT with no step -> pending=2, overflow=1. Pulse step twice -> move_dir=10, then 01, then pending=0. Pulse step again -> move_dir stays 01.
5. Press UP and LEFT on the same cycle -> no push, no key_pulse. With pending=2, press a legal key in the same cycle as step -> pop, then push, pending stays 2, overflow stays 0.
6. PAUSE=1: press LEFT and pulse step -> pending and move_dir unchanged, no key_pulse. With pending=2, assert RST for one cycle -> move_dir=00, pending=0, overflow=0.
